// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master and the register slave.
// Master drives requests and response readies; slave drives the rest.
interface axi4_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating the bus into a flat bank of control registers.
// AW/W collected in any order; out-of-range accesses answer SLVERR.
module axi4_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    axi4_lite_slave_regs_if.slave          bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_LSB    = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(NUM_REGS);
    localparam int IDX_TOP    = IDX_LSB + IDX_W;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("axi4_lite_slave_regs: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_nr
        $error("axi4_lite_slave_regs: NUM_REGS must be a power of two >= 2");
    end

    typedef enum logic {COLLECT, RESP} wstate_t;

    wstate_t               state;
    wstate_t               state_nxt;
    logic                  en;
    logic                  aw_got;
    logic                  w_got;
    logic [IDX_W-1:0]      aw_idx;
    logic                  aw_oor;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  commit;
    logic                  unused;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> IDX_TOP) != '0;
    endfunction

    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid && bus.wready;
    assign b_hs   = bus.bvalid && bus.bready;
    assign ar_hs  = bus.arvalid && bus.arready;
    assign r_hs   = bus.rvalid && bus.rready;
    assign commit = (state == COLLECT) && aw_got && w_got;
    assign unused = ^{bus.awprot, bus.arprot, bus.awaddr, bus.araddr};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en <= 1'b0;
        else        en <= 1'b1;
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // Write FSM next state: commit once both halves are in, leave on B handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (aw_got && w_got) state_nxt = RESP;
            RESP:    if (bus.bready)      state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Write FSM outputs: each channel ready until its half is captured.
    always_comb begin
        bus.awready = en && (state == COLLECT) && !aw_got;
        bus.wready  = en && (state == COLLECT) && !w_got;
        bus.bvalid  = (state == RESP);
    end

    // Capture AW and W payloads independently; flags clear on B handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            aw_idx <= '0;
            aw_oor <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (b_hs) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_idx <= bus.awaddr[IDX_LSB +: IDX_W];
                aw_oor <= out_of_range(bus.awaddr);
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
        end
    end

    // Register bank update, write pulse and write response on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
            bus.bresp    <= 2'b00;
        end else begin
            reg_wr_pulse <= '0;
            if (commit) begin
                bus.bresp <= aw_oor ? 2'b10 : 2'b00;
                if (!aw_oor) begin
                    reg_wr_pulse[aw_idx] <= 1'b1;
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_strb[b]) regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.arready = en && !bus.rvalid;

    // Read channel: one outstanding read, data held until R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.rresp  <= 2'b00;
        end else if (ar_hs) begin
            bus.rvalid <= 1'b1;
            if (out_of_range(bus.araddr)) begin
                bus.rdata <= '0;
                bus.rresp <= 2'b10;
            end else begin
                bus.rdata <= regs[bus.araddr[IDX_LSB +: IDX_W]];
                bus.rresp <= 2'b00;
            end
        end else if (r_hs) begin
            bus.rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs (32-bit data, 16 registers).
// Table of write/read-back vectors plus hand sequences for corner cases.
module tb_axi4_lite_slave_regs;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] reg_out;
    logic [15:0]  reg_wr_pulse;
    int           total = 0;
    int           passed = 0;
    int           tmo = 0;

    axi4_lite_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_slave_regs #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [15:0] pulse;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rg(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic send_aw(input logic [31:0] a);
        bit fire = 0;
        int n = 0;
        bus.awaddr = a;
        bus.awvalid = 1'b1;
        while (!fire && n < 50) begin
            @(negedge clk);
            fire = bus.awready;
            @(posedge clk); #1;
            n++;
        end
        bus.awvalid = 1'b0;
        if (!fire) tmo++;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit fire = 0;
        int n = 0;
        bus.wdata = d;
        bus.wstrb = s;
        bus.wvalid = 1'b1;
        while (!fire && n < 50) begin
            @(negedge clk);
            fire = bus.wready;
            @(posedge clk); #1;
            n++;
        end
        bus.wvalid = 1'b0;
        if (!fire) tmo++;
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit fire = 0;
        int n = 0;
        bus.araddr = a;
        bus.arvalid = 1'b1;
        while (!fire && n < 50) begin
            @(negedge clk);
            fire = bus.arready;
            @(posedge clk); #1;
            n++;
        end
        bus.arvalid = 1'b0;
        if (!fire) tmo++;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [15:0] pulse);
        bit got = 0;
        int n = 0;
        resp = 2'bxx;
        pulse = 'x;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.bvalid) begin
                resp = bus.bresp;
                pulse = reg_wr_pulse;
                got = 1;
            end
        end
        if (!got) tmo++;
        else begin @(posedge clk); #1; end
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
        bit got = 0;
        int n = 0;
        data = 'x;
        resp = 2'bxx;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.rvalid) begin
                data = bus.rdata;
                resp = bus.rresp;
                got = 1;
            end
        end
        if (!got) tmo++;
        else begin @(posedge clk); #1; end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [15:0] pulse);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b(resp, pulse);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        send_ar(a);
        wait_r(d, resp);
    endtask

    initial begin
        logic [1:0]  br;
        logic [1:0]  rr;
        logic [15:0] pl;
        logic [31:0] rd;
        bit          ok;

        vecs[0] = '{32'h0000_0000, 32'h0123_4567, 4'hF, 2'b00, 16'h0001, 32'h0123_4567, 2'b00};
        vecs[1] = '{32'h0000_003C, 32'hCAFE_F00D, 4'hF, 2'b00, 16'h8000, 32'hCAFE_F00D, 2'b00};
        vecs[2] = '{32'h0000_003F, 32'h0000_00AA, 4'h1, 2'b00, 16'h8000, 32'hCAFE_F0AA, 2'b00};
        vecs[3] = '{32'h0000_0020, 32'h5555_5555, 4'h0, 2'b00, 16'h0100, 32'h0000_0000, 2'b00};
        vecs[4] = '{32'h0000_0018, 32'hFFFF_0000, 4'hC, 2'b00, 16'h0040, 32'hFFFF_0000, 2'b00};
        vecs[5] = '{32'h0000_0040, 32'h1234_5678, 4'hF, 2'b10, 16'h0000, 32'h0000_0000, 2'b10};
        vecs[6] = '{32'h1000_0000, 32'h9999_9999, 4'hF, 2'b10, 16'h0000, 32'h0000_0000, 2'b10};

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 1;

        // Reset state and ready rise after release.
        #12;
        check("rst awready", bus.awready, 0);
        check("rst reg_out", reg_out, 0);
        check("rst bvalid/rvalid", {bus.bvalid, bus.rvalid}, 0);
        rst_n = 1'b1;
        #1;
        check("pre-edge readies", {bus.awready, bus.wready, bus.arready}, 0);
        @(posedge clk); #1;
        check("post-edge readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Same-cycle AW/W, response latency and pulse width.
        fork
            send_aw(32'h0C);
            send_w(32'hDEAD_BEEF, 4'hF);
        join
        @(negedge clk);
        check("t1 bvalid early", bus.bvalid, 0);
        @(negedge clk);
        check("t1 bvalid", bus.bvalid, 1);
        check("t1 bresp", bus.bresp, 2'b00);
        check("t1 pulse", reg_wr_pulse, 16'h0008);
        check("t1 reg3", rg(3), 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1 pulse cleared", reg_wr_pulse, 0);
        check("t1 bvalid cleared", bus.bvalid, 0);
        axi_read(32'h0C, rd, rr);
        check("t1 rdata", rd, 32'hDEAD_BEEF);
        check("t1 rresp", rr, 2'b00);

        // W three cycles ahead of AW, then a strobed overwrite.
        send_w(32'h1122_3344, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        send_aw(32'h04);
        wait_b(br, pl);
        check("t2 bresp", br, 2'b00);
        check("t2 pulse", pl, 16'h0002);
        check("t2 reg1", rg(1), 32'h1122_3344);
        axi_write(32'h04, 32'hAABB_CCDD, 4'h5, br, pl);
        check("t2 reg1 strobed", rg(1), 32'h11BB_33DD);

        // Table: write, then read back.
        foreach (vecs[i]) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, br, pl);
            check($sformatf("vec%0d bresp", i), br, vecs[i].bresp);
            check($sformatf("vec%0d pulse", i), pl, vecs[i].pulse);
            axi_read(vecs[i].addr, rd, rr);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].rdata);
            check($sformatf("vec%0d rresp", i), rr, vecs[i].rresp);
        end
        check("oor no alias reg0", rg(0), 32'h0123_4567);

        // Backpressure on B: held response, no new AW/W accepted.
        bus.bready = 1'b0;
        fork
            send_aw(32'h08);
            send_w(32'h0000_0077, 4'hF);
        join
        @(negedge clk);
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        bus.wdata = 32'h99; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.bvalid || bus.bresp != 2'b00 || bus.awready || bus.wready) ok = 0;
        end
        check("t4 hold", ok, 1);
        check("t4 reg2 first", rg(2), 32'h77);
        @(posedge clk); #1;
        bus.bready = 1'b1;
        axi_write(32'h08, 32'h99, 4'hF, br, pl);
        check("t4 second bresp", br, 2'b00);
        check("t4 reg2 second", rg(2), 32'h99);

        // Backpressure on R: held data, arready low.
        bus.rready = 1'b0;
        send_ar(32'h08);
        ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!bus.rvalid || bus.rdata != 32'h99 || bus.arready) ok = 0;
        end
        check("t5 r hold", ok, 1);
        @(posedge clk); #1;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        check("t5 r released", {bus.rvalid, bus.arready}, 2'b01);

        // Read sampled on the commit edge returns the old value.
        send_w(32'h0000_1234, 4'hF);
        fork
            send_aw(32'h08);
            begin @(posedge clk); #1; send_ar(32'h08); end
        join
        fork
            wait_b(br, pl);
            wait_r(rd, rr);
        join
        check("t5 collide old", rd, 32'h99);
        check("t5 collide new reg2", rg(2), 32'h1234);
        axi_read(32'h08, rd, rr);
        check("t5 reread", rd, 32'h1234);

        // Reset while a response is pending.
        bus.bready = 1'b0;
        fork
            send_aw(32'h14);
            send_w(32'hABCD, 4'hF);
        join
        @(negedge clk);
        @(negedge clk);
        check("t6 in resp", bus.bvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 bvalid drop", bus.bvalid, 0);
        check("t6 regs drop", reg_out, 0);
        check("t6 readies low", {bus.awready, bus.wready, bus.arready}, 0);
        bus.bready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6 readies after", {bus.awready, bus.wready, bus.arready, bus.bvalid}, 4'b1110);

        check("timeouts", tmo, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite slave (responder) terminating a master-driven AXI4-Lite bus into a flat bank of NUM_REGS read/write control registers.
- Sits behind the slave end of the team's AXI4-Lite interface. Signal set is identical to the interface's slave view.
- Exposes register contents and per-register write strobes to fabric logic.
- Handles AW and W arriving in either order, applies byte strobes, and returns SLVERR for out-of-range accesses.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr
DATA_WIDTH, 32, bus/register width; only 32 or 64 legal (elaboration error otherwise)
NUM_REGS, 16, number of registers; power of two, >=2
(derived) STRB_WIDTH = DATA_WIDTH/8; IDX_LSB = log2(STRB_WIDTH); IDX_W = log2(NUM_REGS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awaddr  in  ADDR_WIDTH  write address
awprot  in  3  ignored
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  STRB_WIDTH  byte enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arprot  in  3  ignored
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse per written register

Behaviour:
Reset:
- rst_n low asynchronously clears all state. All outputs, including every register, go to 0; the readies are 0 while in reset.
- awready, wready and arready rise on the first clk edge after rst_n goes high.
- Reset mid-transaction drops every pending transaction; no response is issued.

Address decode:
- Register index = addr[IDX_LSB +: IDX_W]. Bits below IDX_LSB are ignored.
- Any set bit at or above IDX_LSB+IDX_W marks the access out of range.

Write FSM, states COLLECT and RESP:
- COLLECT: awready = !aw_got; wready = !w_got. AW and W handshakes are accepted independently, in either order or in the same cycle. Each handshake latches its payload and sets aw_got or w_got; the matching ready drops on the next edge.
- COLLECT with aw_got&&w_got at an edge (commit):
  - In range: write the register, byte lane b updated only if wstrb[b]. Pulse reg_wr_pulse[idx] for one cycle, even if wstrb==0. bresp=OKAY (00).
  - Out of range: no update, no pulse, bresp=SLVERR (10).
  - In all cases bvalid goes to 1 and the FSM enters RESP.
- Latency: bvalid rises on the edge after the edge on which the second of AW/W was captured.
- RESP: awready = wready = 0. bresp and bvalid are held until bvalid&&bready. On that handshake edge: bvalid goes to 0, flags clear, return to COLLECT. Readies are 1 in the next cycle.
- bready stuck low: the block stays in RESP indefinitely and never accepts a new AW or W.

Read channel:
- arready = !rvalid (registered).
- On arvalid&&arready, next edge:
  - In range: rdata = register, rresp = OKAY.
  - Out of range: rdata = 0, rresp = SLVERR.
  - rvalid goes to 1 and arready to 0.
- rdata, rresp and rvalid are held until rvalid&&rready. On that edge rvalid goes to 0 and arready to 1. Maximum throughput is one read per 2 cycles.

Collisions and independence:
- A read sampled on the same edge as a write commit to the same register returns the pre-write value.
- The read and write paths are fully independent; neither stalls the other.

Test Plan:
1. DATA_WIDTH=32, NUM_REGS=16: AW(0x0C) and W(0xDEADBEEF, strb 0xF) in the same cycle, bready=1 -> bvalid 1 cycle later with bresp=00; reg 3 = 0xDEADBEEF; reg_wr_pulse=0x0008 for one cycle; next read of 0x0C returns 0xDEADBEEF with rresp=00.
2. W(0x11223344) 3 cycles before AW(0x04), then wstrb=0x5 with W(0xAABBCCDD) to the same register -> first write gives reg 1 = 0x11223344; after the second, reg 1 = 0x11BB33DD.
3. AW(0x40) or AR(0x40) (out of range) -> bresp=10 with no register change and no pulse; rresp=10 with rdata=0.
4. Write reg 2, then hold bready=0 for 10 cycles -> bvalid and bresp stable throughout, awready=wready=0, a second AW is not accepted; after bready=1 the second write completes normally.
5. rready=0 for 5 cycles after AR(0x08) -> rvalid and rdata stable and arready=0 for 5 cycles; a read issued during a pending write to 0x08 returns the old value if sampled on the commit edge.
6. Pull rst_n low while in RESP with bvalid=1 -> bvalid, all regs and reg_out drop to 0 immediately; readies are 1 one edge after release.
